// File: rtl/cu_pkg.sv
// Shared definitions for the load/store control unit.
//   - cu_state_e    : sequencer states (RST, T0..T7, HALT), 4-bit encoding
//   - instr_class_e : execution class produced by instr_class_decode
//   - ctrl_t        : bundle of the single-bit datapath controls
//   - opcode and ALU select constants
package cu_pkg;

  localparam int CU_OPW  = 5;
  localparam int CU_ALUW = 4;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } cu_state_e;

  typedef enum logic [2:0] {
    CLS_LD,
    CLS_LDI,
    CLS_ST,
    CLS_ALU3,
    CLS_ADDI,
    CLS_BR,
    CLS_NOP,
    CLS_HALT
  } instr_class_e;

  // Opcodes, IR[31:27]
  localparam logic [CU_OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [CU_OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [CU_OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [CU_OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [CU_OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [CU_OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [CU_OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [CU_OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [CU_OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [CU_OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [CU_OPW-1:0] OP_HALT = 5'b11011;

  // ALU selects
  localparam logic [CU_ALUW-1:0] ALU_ADD = 4'b0000;
  localparam logic [CU_ALUW-1:0] ALU_SUB = 4'b0001;
  localparam logic [CU_ALUW-1:0] ALU_AND = 4'b0010;
  localparam logic [CU_ALUW-1:0] ALU_OR  = 4'b0011;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlo_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic y_in;
    logic c_out;
    logic con_in;
    logic write;
  } ctrl_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode decoder.
//   opcode : latched IR[31:27]
//   cls    : execution class; unknown opcodes decode as CLS_NOP
//   alu_op : ALU select used by the class in its Zin state (ADD unless
//            the instruction is a three-register sub/and/or)
module instr_class_decode
  import cu_pkg::*;
(
  input  logic [CU_OPW-1:0]  opcode,
  output instr_class_e       cls,
  output logic [CU_ALUW-1:0] alu_op
);

  always_comb begin
    cls    = CLS_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   cls = CLS_LD;
      OP_LDI:  cls = CLS_LDI;
      OP_ST:   cls = CLS_ST;
      OP_ADD:  begin cls = CLS_ALU3; alu_op = ALU_ADD; end
      OP_SUB:  begin cls = CLS_ALU3; alu_op = ALU_SUB; end
      OP_AND:  begin cls = CLS_ALU3; alu_op = ALU_AND; end
      OP_OR:   begin cls = CLS_ALU3; alu_op = ALU_OR;  end
      OP_ADDI: cls = CLS_ADDI;
      OP_BR:   cls = CLS_BR;
      OP_NOP:  cls = CLS_NOP;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/load_store_control_unit.sv
// Hardwired Moore sequencer for the load/store datapath.
// Fetches (T0..T2), latches the opcode on the T2->T3 edge, then steps
// through the execute states of the decoded instruction class.
//   Clock, Reset (async, active-high) : clocking / forces RST
//   Stop      : halt request, honoured only at an instruction boundary
//   IR, CON   : instruction register and branch condition from datapath
//   PCout..write : datapath control strobes
//   ALUop     : ALU select (0000 whenever nothing is being computed)
//   Run       : 0 only in HALT
//   dbg_state : current sequencer state (cu_state_e encoding)
// There is no handshake: every output is a level valid for the whole
// cycle of the state that drives it.
module load_store_control_unit
  import cu_pkg::*;
#(
  parameter int OPW  = CU_OPW,
  parameter int ALUW = CU_ALUW
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Stop,
  input  logic [31:0]     IR,
  input  logic            CON,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            ZLOout,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Yin,
  output logic            Cout,
  output logic            CONin,
  output logic            write,
  output logic [ALUW-1:0] ALUop,
  output logic            Run,
  output logic [3:0]      dbg_state
);

  cu_state_e       state, state_next, end_state;
  logic [OPW-1:0]  opcode_q;
  instr_class_e    cls;
  logic [ALUW-1:0] alu_dec;
  logic [ALUW-1:0] alu_sel;
  ctrl_t           ctl;
  logic            unused_ir;

  assign unused_ir = ^IR[31-OPW:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= ST_RST;
      opcode_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_T2) opcode_q <= IR[31:32-OPW];
    end
  end

  instr_class_decode u_decode (
    .opcode (opcode_q),
    .cls    (cls),
    .alu_op (alu_dec)
  );

  // Where an instruction goes after its last state: Stop diverts the
  // boundary into HALT, so a running instruction is never cut short.
  assign end_state = Stop ? ST_HALT : ST_T0;

  always_comb begin
    state_next = state;
    case (state)
      ST_RST: state_next = ST_T0;
      ST_T0:  state_next = ST_T1;
      ST_T1:  state_next = ST_T2;
      ST_T2:  state_next = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_HALT: state_next = ST_HALT;
          CLS_NOP:  state_next = end_state;
          default:  state_next = ST_T4;
        endcase
      end
      ST_T4: state_next = ST_T5;
      ST_T5: begin
        case (cls)
          CLS_LDI, CLS_ALU3, CLS_ADDI: state_next = end_state;
          default:                     state_next = ST_T6;
        endcase
      end
      ST_T6:   state_next = (cls == CLS_BR) ? end_state : ST_T7;
      ST_T7:   state_next = end_state;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase
  end

  always_comb begin
    ctl     = '0;
    alu_sel = ALU_ADD;
    case (state)
      ST_T0: begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1;
      end
      ST_T1: begin
        ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
      end
      ST_T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
      end
      ST_T3: begin
        case (cls)
          // Memory ops form the address from Rb, or 0 when Rb is r0 (BAout)
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
          end
          CLS_ALU3, CLS_ADDI: begin
            ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
          end
          CLS_BR: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST, CLS_ADDI: begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
          end
          CLS_ALU3: begin
            ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1;
            alu_sel = alu_dec;
          end
          CLS_BR: begin
            ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_LD, CLS_ST: begin
            ctl.zlo_out = 1'b1; ctl.mar_in = 1'b1;
          end
          CLS_LDI, CLS_ALU3, CLS_ADDI: begin
            ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          CLS_BR: begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_LD: begin
            ctl.read = 1'b1; ctl.mdr_in = 1'b1;
          end
          // Store data goes Ra -> MDR over the bus, not from memory
          CLS_ST: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1;
          end
          // The only non-Moore term: branch target loads only if CON is set
          CLS_BR: begin
            ctl.zlo_out = CON; ctl.pc_in = CON;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin
            ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          CLS_ST:  ctl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign PCout     = ctl.pc_out;
  assign MARin     = ctl.mar_in;
  assign IncPC     = ctl.inc_pc;
  assign Zin       = ctl.z_in;
  assign ZLOout    = ctl.zlo_out;
  assign PCin      = ctl.pc_in;
  assign Read      = ctl.read;
  assign MDRin     = ctl.mdr_in;
  assign MDRout    = ctl.mdr_out;
  assign IRin      = ctl.ir_in;
  assign Gra       = ctl.gra;
  assign Grb       = ctl.grb;
  assign Grc       = ctl.grc;
  assign Rin       = ctl.r_in;
  assign Rout      = ctl.r_out;
  assign BAout     = ctl.ba_out;
  assign Yin       = ctl.y_in;
  assign Cout      = ctl.c_out;
  assign CONin     = ctl.con_in;
  assign write     = ctl.write;
  assign ALUop     = alu_sel;
  assign Run       = (state != ST_HALT);
  assign dbg_state = state;

endmodule
